// File: rtl/uart_cmd_pkg.sv
// Shared definitions for the UART command bridge: FSM states, opcodes,
// response codes and a small opcode-decode helper.
package uart_cmd_pkg;

  // Parser states; CHK is only reachable when UART_CMD_CHKSUM_EN is defined
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DATA,
    ST_CHK,
    ST_EXEC,
    ST_RD_WAIT,
    ST_RESP
  } state_t;

  localparam logic [7:0] CMD_WR  = 8'h01;
  localparam logic [7:0] CMD_RD  = 8'h02;
  localparam logic [7:0] RSP_ACK = 8'h06;
  localparam logic [7:0] RSP_NAK = 8'h15;

  // True for the only two opcodes the bridge understands
  function automatic logic is_valid_cmd(input logic [7:0] cmd);
    return (cmd == CMD_WR) || (cmd == CMD_RD);
  endfunction

endpackage

// File: rtl/uart_cmd_timeout.sv
// Inter-byte idle timer for the command parser. Counts up while enabled,
// clears on request and raises tc once TIMEOUT_CYC-1 is reached; it then
// holds there so the count can never wrap.
module uart_cmd_timeout #(
  parameter int TIMEOUT_CYC = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic tc
);

  localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] cnt;

  assign tc = (cnt == LAST);

  // Clear has priority; otherwise count idle cycles up to the terminal value
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !tc) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_cmd_bridge.sv
// UART register-access bridge: pops framed commands (SYNC, CMD, ADDR,
// [DATA], [CHK]) from the RX FIFO, performs one local-bus read or write and
// pushes a single response byte to the TX FIFO.
// Optional feature macro: UART_CMD_CHKSUM_EN adds a trailing XOR checksum
// byte that must match CMD ^ ADDR [^ DATA] before the bus access happens.
module uart_cmd_bridge #(
  parameter logic [7:0] SYNC_BYTE   = 8'hA5,
  parameter int         TIMEOUT_CYC = 500000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_empty,
  input  logic [7:0] r_data,
  output logic       rd_uart,
  input  logic       tx_full,
  output logic       wr_uart,
  output logic [7:0] w_data,
  output logic       reg_we,
  output logic       reg_re,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  input  logic [7:0] reg_rdata,
  output logic [7:0] err_cnt
);

  import uart_cmd_pkg::*;

  state_t     state;
  state_t     next_state;
  logic [7:0] cmd_q;
  logic [7:0] resp_q;
  logic       err_inc;
  logic       resp_nak;
  logic       in_parse;
  logic       can_pop;
  logic       to_hit;
`ifdef UART_CMD_CHKSUM_EN
  logic [7:0] chk_acc;
`endif

  // Byte-collecting states after the sync byte; only these can time out
  assign in_parse = (state == ST_CMD) || (state == ST_ADDR) ||
                    (state == ST_DATA) || (state == ST_CHK);

  // Popping is suppressed while reset is held so queued bytes survive it
  assign can_pop = !rx_empty && !rst;

  assign w_data = resp_q;

  uart_cmd_timeout #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timeout (
    .clk(clk),
    .rst(rst),
    .clr(rd_uart || !in_parse),
    .inc(in_parse && rx_empty),
    .tc (to_hit)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decode plus the single-cycle pop/push/bus strobes
  always_comb begin
    next_state = state;
    rd_uart    = 1'b0;
    wr_uart    = 1'b0;
    reg_we     = 1'b0;
    reg_re     = 1'b0;
    err_inc    = 1'b0;
    resp_nak   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (can_pop) begin
          rd_uart = 1'b1;
          if (r_data == SYNC_BYTE) begin
            next_state = ST_CMD;
          end
        end
      end
      ST_CMD: begin
        if (can_pop) begin
          rd_uart = 1'b1;
          if (is_valid_cmd(r_data)) begin
            next_state = ST_ADDR;
          end else begin
            next_state = ST_RESP;
            err_inc    = 1'b1;
            resp_nak   = 1'b1;
          end
        end
      end
      ST_ADDR: begin
        if (can_pop) begin
          rd_uart = 1'b1;
          if (cmd_q == CMD_WR) begin
            next_state = ST_DATA;
          end else begin
`ifdef UART_CMD_CHKSUM_EN
            next_state = ST_CHK;
`else
            next_state = ST_EXEC;
`endif
          end
        end
      end
      ST_DATA: begin
        if (can_pop) begin
          rd_uart = 1'b1;
`ifdef UART_CMD_CHKSUM_EN
          next_state = ST_CHK;
`else
          next_state = ST_EXEC;
`endif
        end
      end
`ifdef UART_CMD_CHKSUM_EN
      ST_CHK: begin
        if (can_pop) begin
          rd_uart = 1'b1;
          if (r_data == chk_acc) begin
            next_state = ST_EXEC;
          end else begin
            next_state = ST_RESP;
            err_inc    = 1'b1;
            resp_nak   = 1'b1;
          end
        end
      end
`endif
      ST_EXEC: begin
        reg_we     = (cmd_q == CMD_WR);
        reg_re     = (cmd_q == CMD_RD);
        next_state = (cmd_q == CMD_WR) ? ST_RESP : ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        next_state = ST_RESP;
      end
      ST_RESP: begin
        if (!tx_full) begin
          wr_uart    = 1'b1;
          next_state = ST_IDLE;
        end
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
    if (in_parse && rx_empty && to_hit) begin
      next_state = ST_IDLE;
      err_inc    = 1'b1;
    end
  end

  // Frame fields, response byte and the saturating error counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_q     <= 8'h00;
      reg_addr  <= 8'h00;
      reg_wdata <= 8'h00;
      resp_q    <= 8'h00;
      err_cnt   <= 8'h00;
    end else begin
      if (rd_uart && (state == ST_CMD)) begin
        cmd_q <= r_data;
      end
      if (rd_uart && (state == ST_ADDR)) begin
        reg_addr <= r_data;
      end
      if (rd_uart && (state == ST_DATA)) begin
        reg_wdata <= r_data;
      end
      if (resp_nak) begin
        resp_q <= RSP_NAK;
      end else if ((state == ST_EXEC) && (cmd_q == CMD_WR)) begin
        resp_q <= RSP_ACK;
      end else if (state == ST_RD_WAIT) begin
        resp_q <= reg_rdata;
      end
      if (err_inc && (err_cnt != 8'hFF)) begin
        err_cnt <= err_cnt + 8'd1;
      end
    end
  end

`ifdef UART_CMD_CHKSUM_EN
  // Running XOR of CMD, ADDR and DATA, restarted by each CMD byte
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chk_acc <= 8'h00;
    end else if (rd_uart && (state == ST_CMD)) begin
      chk_acc <= r_data;
    end else if (rd_uart && ((state == ST_ADDR) || (state == ST_DATA))) begin
      chk_acc <= chk_acc ^ r_data;
    end
  end
`endif

endmodule

// File: tb/tb_uart_cmd_bridge.sv
// Self-checking bench for uart_cmd_bridge: RX FIFO and register-bus slave
// models, a table of directed frames, hand-written timing/stall/timeout/
// reset/saturation sequences and a randomized frame stream checked against
// a frame-level reference model. Follows UART_CMD_CHKSUM_EN if defined.
module tb_uart_cmd_bridge;

  localparam int TO = 20;
`ifdef UART_CMD_CHKSUM_EN
  localparam bit CHK_ON = 1'b1;
`else
  localparam bit CHK_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_empty = 1'b1;
  logic [7:0] r_data = 8'h00;
  logic       rd_uart;
  logic       tx_full = 1'b0;
  logic       wr_uart;
  logic [7:0] w_data;
  logic       reg_we;
  logic       reg_re;
  logic [7:0] reg_addr;
  logic [7:0] reg_wdata;
  logic [7:0] reg_rdata = 8'h00;
  logic [7:0] err_cnt;

  logic [7:0] rx_q[$];
  logic [7:0] tx_log[$];
  logic [7:0] we_addr_log[$];
  logic [7:0] we_data_log[$];
  int re_cnt = 0;
  int cyc = 0;
  int last_pop_cyc = 0;
  int last_we_cyc = 0;
  int last_re_cyc = 0;
  int last_tx_cyc = 0;
  int protocol_err = 0;
  logic prev_we = 1'b0;
  logic prev_re = 1'b0;

  logic [7:0] mem_val[256];
  bit         mem_vld[256];
  logic [7:0] ref_val[256];
  bit         ref_vld[256];
  int         exp_err = 0;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [63:0] bytes;
    logic [3:0]  n;
    logic        add_chk;
    logic [7:0]  exp_tx;
    logic        exp_we;
    logic [7:0]  exp_addr;
    logic [7:0]  exp_wdata;
    logic [1:0]  exp_err_inc;
  } vec_t;

  vec_t vecs[6];

  uart_cmd_bridge #(
    .SYNC_BYTE  (8'hA5),
    .TIMEOUT_CYC(TO)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rx_empty (rx_empty),
    .r_data   (r_data),
    .rd_uart  (rd_uart),
    .tx_full  (tx_full),
    .wr_uart  (wr_uart),
    .w_data   (w_data),
    .reg_we   (reg_we),
    .reg_re   (reg_re),
    .reg_addr (reg_addr),
    .reg_wdata(reg_wdata),
    .reg_rdata(reg_rdata),
    .err_cnt  (err_cnt)
  );

  always #5 clk = ~clk;

  // Cycle counter used to timestamp monitored events
  always @(posedge clk) cyc <= cyc + 1;

  // Power-on contents of the register file
  function automatic logic [7:0] dflt(input logic [7:0] a);
    return (a == 8'h20) ? 8'h3C : (a ^ 8'h5A);
  endfunction

  function automatic logic [7:0] ref_read(input logic [7:0] a);
    return ref_vld[a] ? ref_val[a] : dflt(a);
  endfunction

  function automatic int sat(input int e);
    return (e > 255) ? 255 : e;
  endfunction

  // RX FIFO model: pop on rd_uart, present the new head after the edge
  always @(posedge clk) begin
    if (rd_uart && (rx_q.size() > 0)) void'(rx_q.pop_front());
    rx_empty <= (rx_q.size() == 0);
    r_data   <= (rx_q.size() > 0) ? rx_q[0] : 8'h00;
  end

  // Register-bus slave: write storage, read data valid the cycle after reg_re
  always @(posedge clk) begin
    if (reg_we) begin
      mem_val[reg_addr] <= reg_wdata;
      mem_vld[reg_addr] <= 1'b1;
    end
    reg_rdata <= reg_re ? (mem_vld[reg_addr] ? mem_val[reg_addr] : dflt(reg_addr)) : 8'h00;
  end

  // Event monitor sampled mid-cycle, plus protocol sanity counters
  always @(negedge clk) begin
    if (!rst) begin
      if (rd_uart) last_pop_cyc <= cyc;
      if (reg_we) begin
        we_addr_log.push_back(reg_addr);
        we_data_log.push_back(reg_wdata);
        last_we_cyc <= cyc;
      end
      if (reg_re) begin
        re_cnt <= re_cnt + 1;
        last_re_cyc <= cyc;
      end
      if (wr_uart) begin
        tx_log.push_back(w_data);
        last_tx_cyc <= cyc;
      end
      if ((reg_we && reg_re) || (reg_we && prev_we) || (reg_re && prev_re) || (rd_uart && rx_empty))
        protocol_err <= protocol_err + 1;
      prev_we <= reg_we;
      prev_re <= reg_re;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual 0x%0h, required 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] b);
    rx_q.push_back(b);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_tx(input int n, input int budget, input string what);
    int k;
    k = 0;
    while ((tx_log.size() < n) && (k < budget)) begin
      @(posedge clk);
      k++;
    end
    #1;
    checkOutput(what, (tx_log.size() >= n), 1);
  endtask

  task automatic send_frame(input logic [7:0] cmd, input logic [7:0] addr, input logic [7:0] data, input bit with_data);
    logic [7:0] chk;
    applyStimulus(8'hA5);
    applyStimulus(cmd);
    applyStimulus(addr);
    chk = cmd ^ addr;
    if (with_data) begin
      applyStimulus(data);
      chk = chk ^ data;
    end
    if (CHK_ON) applyStimulus(chk);
  endtask

  task automatic ref_write(input logic [7:0] a, input logic [7:0] d);
    ref_val[a] = d;
    ref_vld[a] = 1'b1;
  endtask

  initial begin
    logic [7:0] frame[$];
    logic [7:0] exp_tx_q[$];
    logic [7:0] exp_wa[$];
    logic [7:0] exp_wd[$];
    logic [7:0] b, chk, a, d, c;
    int tx_base, we_base, re_base, kind, gap, bad;
    bit started;

    vecs[0] = '{bytes: 64'hA5_01_10_5C_00_00_00_00, n: 4'd4, add_chk: 1'b1, exp_tx: 8'h06,
                exp_we: 1'b1, exp_addr: 8'h10, exp_wdata: 8'h5C, exp_err_inc: 2'd0};
    vecs[1] = '{bytes: 64'hA5_02_20_00_00_00_00_00, n: 4'd3, add_chk: 1'b1, exp_tx: 8'h3C,
                exp_we: 1'b0, exp_addr: 8'h20, exp_wdata: 8'h5C, exp_err_inc: 2'd0};
    vecs[2] = '{bytes: 64'hFF_00_A5_01_01_01_00_00, n: 4'd6, add_chk: 1'b1, exp_tx: 8'h06,
                exp_we: 1'b1, exp_addr: 8'h01, exp_wdata: 8'h01, exp_err_inc: 2'd0};
    vecs[3] = '{bytes: 64'hA5_07_00_00_00_00_00_00, n: 4'd2, add_chk: 1'b0, exp_tx: 8'h15,
                exp_we: 1'b0, exp_addr: 8'h01, exp_wdata: 8'h01, exp_err_inc: 2'd1};
    vecs[4] = '{bytes: 64'hA5_02_10_00_00_00_00_00, n: 4'd3, add_chk: 1'b1, exp_tx: 8'h5C,
                exp_we: 1'b0, exp_addr: 8'h10, exp_wdata: 8'h01, exp_err_inc: 2'd0};
`ifdef UART_CMD_CHKSUM_EN
    vecs[5] = '{bytes: 64'hA5_01_10_5C_00_00_00_00, n: 4'd5, add_chk: 1'b0, exp_tx: 8'h15,
                exp_we: 1'b0, exp_addr: 8'h10, exp_wdata: 8'h5C, exp_err_inc: 2'd1};
`else
    vecs[5] = '{bytes: 64'hA5_01_33_C3_00_00_00_00, n: 4'd4, add_chk: 1'b1, exp_tx: 8'h06,
                exp_we: 1'b1, exp_addr: 8'h33, exp_wdata: 8'hC3, exp_err_inc: 2'd0};
`endif

    // Reset state
    rst = 1'b1;
    cycles(3);
    checkOutput("reset_strobes", {28'd0, rd_uart, wr_uart, reg_we, reg_re}, 32'd0);
    checkOutput("reset_reg_addr", reg_addr, 8'h00);
    checkOutput("reset_reg_wdata", reg_wdata, 8'h00);
    checkOutput("reset_w_data", w_data, 8'h00);
    checkOutput("reset_err_cnt", err_cnt, 8'h00);
    rst = 1'b0;
    cycles(2);

    // Directed frame table
    for (int i = 0; i < 6; i++) begin
      tx_base = tx_log.size();
      we_base = we_addr_log.size();
      started = 1'b0;
      chk = 8'h00;
      for (int k = 0; k < int'(vecs[i].n); k++) begin
        b = vecs[i].bytes[63 - 8*k -: 8];
        applyStimulus(b);
        if (started) chk = chk ^ b;
        if (!started && (b == 8'hA5)) started = 1'b1;
      end
      if (vecs[i].add_chk && CHK_ON) applyStimulus(chk);
      wait_tx(tx_base + 1, 200, $sformatf("vec%0d_done", i));
      cycles(3);
      exp_err = exp_err + int'(vecs[i].exp_err_inc);
      if (tx_log.size() > tx_base)
        checkOutput($sformatf("vec%0d_tx", i), tx_log[tx_base], vecs[i].exp_tx);
      checkOutput($sformatf("vec%0d_tx_count", i), tx_log.size() - tx_base, 1);
      checkOutput($sformatf("vec%0d_we_count", i), we_addr_log.size() - we_base, {31'd0, vecs[i].exp_we});
      if (vecs[i].exp_we && (we_addr_log.size() > we_base)) begin
        checkOutput($sformatf("vec%0d_we_addr", i), we_addr_log[we_base], vecs[i].exp_addr);
        checkOutput($sformatf("vec%0d_we_data", i), we_data_log[we_base], vecs[i].exp_wdata);
        ref_write(vecs[i].exp_addr, vecs[i].exp_wdata);
      end
      checkOutput($sformatf("vec%0d_reg_addr", i), reg_addr, vecs[i].exp_addr);
      checkOutput($sformatf("vec%0d_reg_wdata", i), reg_wdata, vecs[i].exp_wdata);
      checkOutput($sformatf("vec%0d_err_cnt", i), err_cnt, sat(exp_err));
    end

    // Write latency: reg_we one cycle after the last pop, ACK one after that
    tx_base = tx_log.size();
    send_frame(8'h01, 8'h44, 8'h99, 1'b1);
    wait_tx(tx_base + 1, 200, "wr_timing_done");
    cycles(2);
    ref_write(8'h44, 8'h99);
    checkOutput("wr_timing_we", last_we_cyc - last_pop_cyc, 1);
    checkOutput("wr_timing_tx", last_tx_cyc - last_pop_cyc, 2);
    checkOutput("wr_timing_byte", tx_log[tx_log.size()-1], 8'h06);

    // Read latency: reg_re one cycle after the last pop, data three after
    tx_base = tx_log.size();
    send_frame(8'h02, 8'h44, 8'h00, 1'b0);
    wait_tx(tx_base + 1, 200, "rd_timing_done");
    cycles(2);
    checkOutput("rd_timing_re", last_re_cyc - last_pop_cyc, 1);
    checkOutput("rd_timing_tx", last_tx_cyc - last_pop_cyc, 3);
    checkOutput("rd_timing_byte", tx_log[tx_log.size()-1], 8'h99);

    // TX full stall: response held off, then exactly one push
    tx_base = tx_log.size();
    re_base = re_cnt;
    tx_full = 1'b1;
    send_frame(8'h02, 8'h10, 8'h00, 1'b0);
    cycles(100);
    checkOutput("stall_no_push", tx_log.size() - tx_base, 0);
    checkOutput("stall_read_done", re_cnt - re_base, 1);
    tx_full = 1'b0;
    wait_tx(tx_base + 1, 50, "stall_release_done");
    cycles(10);
    checkOutput("stall_single_push", tx_log.size() - tx_base, 1);
    checkOutput("stall_byte", tx_log[tx_log.size()-1], ref_read(8'h10));

    // Timeout mid-frame: no access, no response, error counted
    tx_base = tx_log.size();
    re_base = re_cnt;
    applyStimulus(8'hA5);
    applyStimulus(8'h02);
    cycles(TO + 10);
    exp_err++;
    checkOutput("timeout_err_cnt", err_cnt, sat(exp_err));
    checkOutput("timeout_no_tx", tx_log.size() - tx_base, 0);
    checkOutput("timeout_no_re", re_cnt - re_base, 0);
    send_frame(8'h02, 8'h20, 8'h00, 1'b0);
    wait_tx(tx_base + 1, 200, "timeout_recover_done");
    checkOutput("timeout_recover_byte", tx_log[tx_log.size()-1], ref_read(8'h20));

    // A gap well inside the timeout must not abort the frame
    tx_base = tx_log.size();
    applyStimulus(8'hA5);
    applyStimulus(8'h02);
    cycles(TO - 6);
    applyStimulus(8'h20);
    if (CHK_ON) applyStimulus(8'h22);
    wait_tx(tx_base + 1, 200, "short_gap_done");
    cycles(2);
    checkOutput("short_gap_byte", tx_log[tx_log.size()-1], ref_read(8'h20));
    checkOutput("short_gap_err_cnt", err_cnt, sat(exp_err));

    // Reset mid-frame discards the partial frame and clears the counters
    we_base = we_addr_log.size();
    applyStimulus(8'hA5);
    applyStimulus(8'h01);
    applyStimulus(8'h55);
    cycles(6);
    rst = 1'b1;
    cycles(2);
    checkOutput("midrst_strobes", {28'd0, rd_uart, wr_uart, reg_we, reg_re}, 32'd0);
    checkOutput("midrst_err_cnt", err_cnt, 8'h00);
    checkOutput("midrst_reg_addr", reg_addr, 8'h00);
    rst = 1'b0;
    exp_err = 0;
    cycles(2);
    tx_base = tx_log.size();
    send_frame(8'h01, 8'h56, 8'h77, 1'b1);
    wait_tx(tx_base + 1, 200, "midrst_frame_done");
    cycles(2);
    ref_write(8'h56, 8'h77);
    checkOutput("midrst_ack", tx_log[tx_log.size()-1], 8'h06);
    checkOutput("midrst_we_count", we_addr_log.size() - we_base, 1);
    checkOutput("midrst_we_addr", we_addr_log[we_addr_log.size()-1], 8'h56);

    // Randomized frame stream against the frame-level reference model
    tx_base = tx_log.size();
    we_base = we_addr_log.size();
    for (int f = 0; f < 40; f++) begin
      frame.delete();
      kind = $urandom_range(0, CHK_ON ? 4 : 3);
      a = 8'($urandom_range(0, 7));
      d = 8'($urandom);
      case (kind)
        0: begin
          b = 8'($urandom);
          if (b == 8'hA5) b = 8'h5A;
          frame.push_back(b);
        end
        1: begin
          frame = '{8'hA5, 8'h01, a, d};
          if (CHK_ON) frame.push_back(8'h01 ^ a ^ d);
          exp_tx_q.push_back(8'h06);
          exp_wa.push_back(a);
          exp_wd.push_back(d);
          ref_write(a, d);
        end
        2: begin
          frame = '{8'hA5, 8'h02, a};
          if (CHK_ON) frame.push_back(8'h02 ^ a);
          exp_tx_q.push_back(ref_read(a));
        end
        3: begin
          c = 8'($urandom);
          if ((c == 8'h01) || (c == 8'h02)) c = 8'h07;
          frame = '{8'hA5, c};
          exp_tx_q.push_back(8'h15);
          exp_err++;
        end
        default: begin
          frame = '{8'hA5, 8'h01, a, d};
          frame.push_back(8'h01 ^ a ^ d ^ 8'($urandom_range(1, 255)));
          exp_tx_q.push_back(8'h15);
          exp_err++;
        end
      endcase
      foreach (frame[k]) begin
        applyStimulus(frame[k]);
        gap = $urandom_range(0, 3);
        repeat (gap) begin
          tx_full = ($urandom_range(0, 3) == 0);
          cycles(1);
        end
      end
    end
    tx_full = 1'b0;
    wait_tx(tx_base + exp_tx_q.size(), 3000, "rand_done");
    cycles(5);
    checkOutput("rand_tx_count", tx_log.size() - tx_base, exp_tx_q.size());
    foreach (exp_tx_q[k])
      if (tx_base + k < tx_log.size())
        checkOutput($sformatf("rand_tx%0d", k), tx_log[tx_base + k], exp_tx_q[k]);
    checkOutput("rand_we_count", we_addr_log.size() - we_base, exp_wa.size());
    foreach (exp_wa[k])
      if (we_base + k < we_addr_log.size()) begin
        checkOutput($sformatf("rand_we_addr%0d", k), we_addr_log[we_base + k], exp_wa[k]);
        checkOutput($sformatf("rand_we_data%0d", k), we_data_log[we_base + k], exp_wd[k]);
      end
    checkOutput("rand_err_cnt", err_cnt, sat(exp_err));

    // 256 bad commands drive err_cnt into saturation
    tx_base = tx_log.size();
    for (int k = 0; k < 256; k++) begin
      applyStimulus(8'hA5);
      applyStimulus(8'h07);
    end
    exp_err = exp_err + 256;
    wait_tx(tx_base + 256, 4000, "sat_done");
    cycles(5);
    bad = 0;
    for (int k = tx_base; k < tx_log.size(); k++)
      if (tx_log[k] != 8'h15) bad++;
    checkOutput("sat_nak_bytes", bad, 0);
    checkOutput("sat_err_cnt", err_cnt, sat(exp_err));

    checkOutput("protocol_violations", protocol_err, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_cmd_bridge.md
# uart_cmd_bridge

Byte-level command interpreter downstream of the UART receive FIFO and upstream of the UART transmit FIFO. It pops framed host commands from the RX side, performs one 8-bit register read or write on a simple local bus, and pushes a one-byte response into the TX side. It turns the UART into a register-access port for the rest of the FPGA.

## Interface
- SYNC_BYTE, 8'hA5, frame start marker.
- TIMEOUT_CYC, 500000, maximum idle clk cycles between bytes inside a frame; minimum 2.
- clk  in  1  system clock, 50 MHz nominal.
- rst  in  1  reset; asynchronous, active-high.
- rx_empty  in  1  RX FIFO empty flag.
- r_data  in  8  RX FIFO head byte; valid while rx_empty=0.
- rd_uart  out  1  RX FIFO pop; one-cycle pulse.
- tx_full  in  1  TX FIFO full flag.
- wr_uart  out  1  TX FIFO push; one-cycle pulse.
- w_data  out  8  byte pushed; valid with wr_uart.
- reg_we  out  1  register write strobe; one cycle.
- reg_re  out  1  register read strobe; one cycle.
- reg_addr  out  8  register address.
- reg_wdata  out  8  write data.
- reg_rdata  in  8  read data; valid the cycle after reg_re.
- err_cnt  out  8  saturating count of dropped or rejected frames.

## Operation
- Frame: SYNC_BYTE, CMD, ADDR, [DATA if CMD=8'h01], [CHK if checksum enabled].
- CMD 8'h01 = write, 8'h02 = read. Any other value: NAK response, err_cnt++, return to IDLE. ADDR is not consumed.
- Responses: write OK -> 8'h06 (ACK). Read OK -> reg_rdata byte. Error -> 8'h15 (NAK).
- States: IDLE, CMD, ADDR, DATA, CHK, EXEC, RD_WAIT, RESP.
  - IDLE pops bytes and discards every one that is not SYNC_BYTE.
  - CMD, ADDR, DATA and CHK each pop one byte and advance.
  - EXEC pulses reg_we or reg_re.
  - RD_WAIT captures reg_rdata.
  - RESP holds until tx_full=0, pulses wr_uart, then returns to IDLE.
- Pop rule: rd_uart=1 only in a byte-consuming state with rx_empty=0. r_data is captured on the same edge. Back-to-back pops on consecutive cycles are legal.
- Timeout: counter clears on every pop and on entry to CMD. It increments while in CMD/ADDR/DATA/CHK with rx_empty=1. At TIMEOUT_CYC-1: go to IDLE, err_cnt++, no response, no register access.
- RESP has no timeout; it stalls indefinitely on tx_full.
- err_cnt saturates at 8'hFF.
- Reset values: all outputs 0, state IDLE, counters 0.
- Reset mid-frame discards the partial frame. Bytes already queued in the RX FIFO are parsed afresh from IDLE.

## Timing
- Write path, last byte popped at edge N: reg_we high in cycle N+1 (EXEC); wr_uart with 8'h06 in cycle N+2 if tx_full=0.
- Read path, last byte popped at edge N: reg_re high in cycle N+1; reg_rdata sampled in cycle N+2 (RD_WAIT); wr_uart with the data in cycle N+3 if tx_full=0.
- reg_addr and reg_wdata are stable from EXEC until the next frame's ADDR/DATA capture.
- reg_we and reg_re are never asserted together or for more than one cycle.
- Never more than one rd_uart or one wr_uart per cycle.
- rd_uart is never asserted in EXEC, RD_WAIT or RESP.

## Configuration
- UART_CMD_CHKSUM_EN defined:
  - CHK byte is required: XOR of CMD, ADDR and (for writes) DATA.
  - On mismatch: NAK, err_cnt++, no reg_we or reg_re.
- UART_CMD_CHKSUM_EN undefined:
  - No CHK state or byte; DATA/ADDR go directly to EXEC.
  - Checksum logic is absent.

## Structure
- Package uart_cmd_pkg holds:
  - state enum;
  - opcode constants CMD_WR=8'h01 and CMD_RD=8'h02;
  - response constants RSP_ACK=8'h06 and RSP_NAK=8'h15.
- One sub-module, uart_cmd_timeout: a clearable counter with a terminal-count flag, parameterised by TIMEOUT_CYC. Its width is derived with $clog2.

## Test plan
- Write, RX bytes A5 01 10 5C [4D] -> one reg_we pulse with reg_addr=8'h10 and reg_wdata=8'h5C; TX receives 8'h06.
- Read, A5 02 20 [22] with reg_rdata=8'h3C -> reg_re pulse with reg_addr=8'h20; TX receives 8'h3C in cycle N+3.
- Garbage then a valid frame, FF 00 A5 01 01 01 [01] -> leading bytes discarded; write performed; ACK returned.
- Bad command A5 07 -> TX receives 8'h15; err_cnt=1; next frame parsed correctly. With checksum enabled: A5 01 10 5C 00 -> NAK, no reg_we.
- Timeout: A5 02 then silence for TIMEOUT_CYC cycles -> back in IDLE; err_cnt incremented; no TX byte.
- tx_full held high for 100 cycles during RESP -> wr_uart held off, then a single push; 256 bad frames -> err_cnt saturates at 8'hFF.
